// File: rtl/core_sequencer.sv
// core_sequencer: single-clock multi-cycle instruction sequencer.
// Walks FETCH -> EXEC -> [MEM] -> WB, talking to instruction and data memories
// over variable-latency req/ack/err handshakes. All architectural updates
// (PC, register-file and CSR write strobes, retire count) happen only in WB.
// Supports free-run, pause at the instruction boundary, single-step, ebreak
// halt, and bus-error / timeout traps.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_req/addr/ack/err/rdata  instruction fetch handshake
//   inst, pc, next_pc            instruction register, PC, PC-next from decode
//   is_load, is_store, halt_req  decoder flags (halt_req = ebreak)
//   rd_we_in, csr_we_in          decoder write requests, gated into rf_we/csr_we
//   dmem_req/we/ack/err/rdata    data access handshake
//   ld_data                      registered load data
//   commit                       one-cycle retire pulse
//   run, step                    free-run enable, single-step pulse (PAUSE only)
//   halted, exc, exc_cause       sticky halt, sticky trap and its cause
//   state, retired               debug FSM state, retired-instruction count
module core_sequencer #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = 32'h8000_0000,
    parameter int unsigned       TIMEOUT  = 255,
    parameter int unsigned       CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic             imem_err,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,
    output logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] next_pc,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             halt_req,
    input  logic             rd_we_in,
    input  logic             csr_we_in,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             dmem_err,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] ld_data,
    output logic             rf_we,
    output logic             csr_we,
    output logic             commit,
    input  logic             run,
    input  logic             step,
    output logic             halted,
    output logic             exc,
    output logic [1:0]       exc_cause,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;
    localparam logic [2:0] ST_PAUSE = 3'd5;
    localparam logic [2:0] ST_HALT  = 3'd6;
    localparam logic [2:0] ST_ERROR = 3'd7;

    localparam logic [1:0] CAUSE_IMEM    = 2'b01;
    localparam logic [1:0] CAUSE_DMEM    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic [2:0]       state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [15:0]      wait_q, wait_d;
    logic [31:0]      inst_q, inst_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ld_q, ld_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic             step_pend_q, step_pend_d;
    // Store/load direction captured in EXEC so dmem_we cannot move mid-access.
    logic             mem_we_q, mem_we_d;

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        wait_d      = '0;  // any state change clears the wait counter
        inst_d      = inst_q;
        pc_d        = pc_q;
        ld_d        = ld_q;
        ret_d       = ret_q;
        step_pend_d = step_pend_q;
        mem_we_d    = mem_we_q;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;

            ST_FETCH: begin
                // err beats ack; ack beats timeout.
                if (imem_err) begin
                    state_d = ST_ERROR;
                    cause_d = CAUSE_IMEM;
                end else if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = ST_EXEC;
                end else if (wait_q == TIMEOUT_W) begin
                    state_d = ST_ERROR;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            ST_EXEC: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (is_load || is_store) begin
                    state_d  = ST_MEM;
                    mem_we_d = is_store;
                end else begin
                    state_d = ST_WB;
                end
            end

            ST_MEM: begin
                if (dmem_err) begin
                    state_d = ST_ERROR;
                    cause_d = CAUSE_DMEM;
                end else if (dmem_ack) begin
                    if (!mem_we_q) begin
                        ld_d = dmem_rdata;
                    end
                    state_d = ST_WB;
                end else if (wait_q == TIMEOUT_W) begin
                    state_d = ST_ERROR;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            ST_WB: begin
                pc_d        = next_pc;
                ret_d       = ret_q + CNT_W'(1);
                state_d     = (run && !step_pend_q) ? ST_FETCH : ST_PAUSE;
                step_pend_d = 1'b0;
            end

            ST_PAUSE: begin
                // run has priority; a simultaneous step is ignored.
                if (run) begin
                    state_d = ST_FETCH;
                end else if (step) begin
                    state_d     = ST_FETCH;
                    step_pend_d = 1'b1;
                end
            end

            default: ;  // HALT and ERROR are absorbing
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RESET;
            cause_q     <= 2'b00;
            wait_q      <= '0;
            inst_q      <= NOP;
            pc_q        <= RESET_PC;
            ld_q        <= '0;
            ret_q       <= '0;
            step_pend_q <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            wait_q      <= wait_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            ld_q        <= ld_d;
            ret_q       <= ret_d;
            step_pend_q <= step_pend_d;
            mem_we_q    <= mem_we_d;
        end
    end

    // Strobes and requests are masked by rst so an in-flight request drops
    // in the same cycle reset is raised.
    assign imem_req  = !rst && (state_q == ST_FETCH);
    assign dmem_req  = !rst && (state_q == ST_MEM);
    assign dmem_we   = dmem_req && mem_we_q;
    assign commit    = !rst && (state_q == ST_WB);
    assign rf_we     = commit && rd_we_in;
    assign csr_we    = commit && csr_we_in;
    assign halted    = !rst && (state_q == ST_HALT);
    assign exc       = !rst && (state_q == ST_ERROR);

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign inst      = inst_q;
    assign ld_data   = ld_q;
    assign exc_cause = cause_q;
    assign state     = state_q;
    assign retired   = ret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer. Inputs are driven and outputs sampled on
// the falling clock edge; cycle n means n rising edges after reset release.
// TIMEOUT is 5 so the 5-wait-cycle load also lands ack on the timeout cycle.
module tb_core_sequencer;

    localparam int unsigned TMO  = 5;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] LW   = 32'h0000_2103;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, imem_err;
    logic [31:0] imem_addr, imem_rdata, inst, pc, next_pc;
    logic        is_load, is_store, halt_req, rd_we_in, csr_we_in;
    logic        dmem_req, dmem_we, dmem_ack, dmem_err;
    logic [31:0] dmem_rdata, ld_data;
    logic        rf_we, csr_we, commit, run, step, halted, exc;
    logic [1:0]  exc_cause;
    logic [2:0]  state;
    logic [63:0] retired;

    logic imem_auto, dmem_auto;
    int   dwait;
    int   dcnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Decode stand-in: sequential next PC.
    assign next_pc  = pc + 32'd4;
    // Zero-wait instruction memory when enabled.
    assign imem_ack = imem_auto && imem_req;
    // Data memory acks after dwait wait cycles.
    always @(posedge clk) dcnt <= dmem_req ? dcnt + 1 : 0;
    assign dmem_ack = dmem_auto && dmem_req && (dcnt == dwait);

    core_sequencer #(
        .WIDTH    (32),
        .RESET_PC (BASE),
        .TIMEOUT  (TMO),
        .CNT_W    (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_err   (imem_err),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .pc         (pc),
        .next_pc    (next_pc),
        .is_load    (is_load),
        .is_store   (is_store),
        .halt_req   (halt_req),
        .rd_we_in   (rd_we_in),
        .csr_we_in  (csr_we_in),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .dmem_err   (dmem_err),
        .dmem_rdata (dmem_rdata),
        .ld_data    (ld_data),
        .rf_we      (rf_we),
        .csr_we     (csr_we),
        .commit     (commit),
        .run        (run),
        .step       (step),
        .halted     (halted),
        .exc        (exc),
        .exc_cause  (exc_cause),
        .state      (state),
        .retired    (retired)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},   64'(state),     64'd0);
        check({tag, "_pc"},      64'(pc),        64'(BASE));
        check({tag, "_inst"},    64'(inst),      64'(NOP));
        check({tag, "_retired"}, retired,        64'd0);
        check({tag, "_ld"},      64'(ld_data),   64'd0);
        check({tag, "_cause"},   64'(exc_cause), 64'd0);
        check({tag, "_strobes"},
              64'({imem_req, dmem_req, dmem_we, rf_we, csr_we, commit, halted, exc}), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        cyc();
        cyc();
        check_reset(tag);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_err = 1'b0; imem_rdata = ADDI;
        is_load = 1'b0; is_store = 1'b0; halt_req = 1'b0;
        rd_we_in = 1'b1; csr_we_in = 1'b0;
        dmem_err = 1'b0; dmem_rdata = 32'h0; run = 1'b1; step = 1'b0;
        imem_auto = 1'b1; dmem_auto = 1'b1; dwait = 5;
        @(negedge clk);

        // ALU stream: commits on cycles 3, 6, 9.
        do_reset("rst0");
        for (int n = 1; n <= 9; n++) begin
            cyc();
            check("alu_commit", 64'(commit), 64'(n % 3 == 0));
            check("alu_rf_we",  64'(rf_we),  64'(n % 3 == 0));
            check("alu_csr_we", 64'(csr_we), 64'd0);
            check("alu_pc",     64'(pc),     64'(BASE + 32'(4 * ((n - 1) / 3))));
            check("alu_state",  64'(state),
                  (n % 3 == 1) ? 64'd1 : (n % 3 == 2) ? 64'd2 : 64'd4);
        end
        check("alu_inst", 64'(inst), 64'(ADDI));
        cyc();  // cycle 10: FETCH of the load
        check("alu_pc_end",   64'(pc),    64'(BASE + 32'hC));
        check("alu_retired",  retired,    64'd3);
        check("alu_fetch",    64'(state), 64'd1);

        // Load with 5 wait cycles.
        is_load = 1'b1; imem_rdata = LW; dmem_rdata = 32'hDEAD_BEEF;
        cyc();
        check("ld_exec", 64'(state), 64'd2);
        check("ld_inst", 64'(inst),  64'(LW));
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("ld_req",    64'(dmem_req), 64'd1);
            check("ld_we",     64'(dmem_we),  64'd0);
            check("ld_commit", 64'(commit),   64'd0);
        end
        cyc();
        check("ld_wb",      64'(state),    64'd4);
        check("ld_commit1", 64'(commit),   64'd1);
        check("ld_req_off", 64'(dmem_req), 64'd0);
        check("ld_data",    64'(ld_data),  64'hDEAD_BEEF);

        // ebreak at pc 8000_0010.
        is_load = 1'b0; halt_req = 1'b1;
        cyc();
        check("hlt_pc",      64'(pc), 64'(BASE + 32'h10));
        check("hlt_retired", retired, 64'd4);
        cyc();
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("hlt_state",   64'(state),    64'd6);
            check("hlt_halted",  64'(halted),   64'd1);
            check("hlt_imem",    64'(imem_req), 64'd0);
            check("hlt_pc",      64'(pc),       64'(BASE + 32'h10));
            check("hlt_retired", retired,       64'd4);
            check("hlt_commit",  64'(commit),   64'd0);
        end

        // Pause and single-step.
        halt_req = 1'b0; imem_rdata = ADDI;
        do_reset("rst1");
        cyc();
        cyc();
        run = 1'b0;
        cyc();
        check("ps_commit", 64'(commit), 64'd1);
        cyc();
        check("ps_pause",   64'(state), 64'd5);
        check("ps_retired", retired,    64'd1);
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("ps_hold", 64'(state),    64'd5);
            check("ps_imem", 64'(imem_req), 64'd0);
        end
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("st_fetch", 64'(state), 64'd1);
        cyc();
        cyc();
        check("st_commit", 64'(commit), 64'd1);
        cyc();
        check("st_pause",   64'(state), 64'd5);
        check("st_retired", retired,    64'd2);
        cyc();
        check("st_hold", 64'(state), 64'd5);
        run = 1'b1; step = 1'b1;
        cyc();
        step = 1'b0;
        check("rs_fetch", 64'(state), 64'd1);
        cyc();
        cyc();
        cyc();
        check("rs_free",    64'(state), 64'd1);
        check("rs_retired", retired,    64'd3);

        // Reset during a pending store.
        is_store = 1'b1; dmem_auto = 1'b0;
        cyc();
        cyc();
        check("mr_req", 64'(dmem_req), 64'd1);
        check("mr_we",  64'(dmem_we),  64'd1);
        cyc();
        check("mr_req2", 64'(dmem_req), 64'd1);
        rst = 1'b1;
        #1;
        check("mr_drop", 64'(dmem_req), 64'd0);
        cyc();
        check_reset("mr");
        cyc();

        // Store with dmem_err: cause 10, no rf_we.
        dmem_err = 1'b1;
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            cyc();
            check("se_rf_we",  64'(rf_we),  64'd0);
            check("se_commit", 64'(commit), 64'd0);
            if (n == 3) check("se_req", 64'(dmem_req), 64'd1);
            if (n >= 4) begin
                check("se_state", 64'(state),     64'd7);
                check("se_exc",   64'(exc),       64'd1);
                check("se_cause", 64'(exc_cause), 64'd2);
            end
        end

        // Fetch timeout: 5 wait cycles then ERROR cause 11.
        dmem_err = 1'b0; is_store = 1'b0; imem_auto = 1'b0;
        do_reset("rst2");
        for (int n = 1; n <= 6; n++) begin
            cyc();
            check("to_state", 64'(state),    64'd1);
            check("to_req",   64'(imem_req), 64'd1);
        end
        cyc();
        check("to_err",   64'(state),     64'd7);
        check("to_cause", 64'(exc_cause), 64'd3);
        check("to_req0",  64'(imem_req),  64'd0);

        // imem_err together with ack: err wins.
        imem_auto = 1'b1; imem_err = 1'b1; imem_rdata = 32'h1234_5678;
        do_reset("rst3");
        cyc();
        check("ie_req", 64'(imem_req), 64'd1);
        cyc();
        check("ie_state", 64'(state),     64'd7);
        check("ie_cause", 64'(exc_cause), 64'd1);
        check("ie_inst",  64'(inst),      64'(NOP));
        check("ie_exc",   64'(exc),       64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
